// File: rtl/cpu_clk_gen_pkg.sv
// Shared defaults for the Minisys-1A clock generator: board/output frequencies
// and lock delay, plus the accumulator width helper used by the dividers.
package cpu_clk_gen_pkg;

  localparam int IN_FREQ_DEF     = 100;
  localparam int CPU_FREQ_DEF    = 22;
  localparam int UPG_FREQ_DEF    = 10;
  localparam int LOCK_CYCLES_DEF = 16;

  // acc + INC never exceeds 2*MOD-1 when INC <= MOD, so this width never overflows
  function automatic int acc_width(input int modulus);
    return $clog2(2 * modulus);
  endfunction

endpackage

// File: rtl/frac_clk_div.sv
// Fractional toggle divider: phase accumulator of step INC modulo MOD; the
// output toggles each time the accumulator wraps.
module frac_clk_div
  import cpu_clk_gen_pkg::*;
#(
  parameter int INC = 44,
  parameter int MOD = 100
) (
  input  logic clk_in1,
  input  logic resetn,
  output logic clk_out
);

  localparam int W = acc_width(MOD);
  localparam logic [W-1:0] INC_W = W'(INC);
  localparam logic [W-1:0] MOD_W = W'(MOD);

  if (INC <= 0 || INC > MOD) begin : g_bad_cfg
    $error("frac_clk_div: INC=%0d must be in 1..MOD=%0d", INC, MOD);
  end

  logic [W-1:0] acc;
  logic [W-1:0] sum;
  logic         wrap;

  always_comb begin
    sum  = acc + INC_W;
    wrap = (sum >= MOD_W);
  end

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      acc     <= '0;
      clk_out <= 1'b0;
    end else begin
      acc <= wrap ? (sum - MOD_W) : sum;
      if (wrap) clk_out <= ~clk_out;
    end
  end

endmodule

// File: rtl/cpu_clk_gen.sv
// Minisys-1A clock generator: CPU and upg clocks from fractional toggle dividers,
// plus a lock indicator raised a fixed number of edges after reset release.
module cpu_clk_gen
  import cpu_clk_gen_pkg::*;
#(
  parameter int IN_FREQ_MHZ   = IN_FREQ_DEF,
  parameter int OUT1_FREQ_MHZ = CPU_FREQ_DEF,
  parameter int OUT2_FREQ_MHZ = UPG_FREQ_DEF,
  parameter int LOCK_CYCLES   = LOCK_CYCLES_DEF
) (
  input  logic clk_in1,
  input  logic resetn,
  output logic clk_out1,
  output logic clk_out2,
  output logic locked
);

  if (OUT1_FREQ_MHZ <= 0 || 2 * OUT1_FREQ_MHZ > IN_FREQ_MHZ) begin : g_bad_out1
    $error("cpu_clk_gen: OUT1_FREQ_MHZ=%0d out of range for IN_FREQ_MHZ=%0d",
           OUT1_FREQ_MHZ, IN_FREQ_MHZ);
  end
  if (OUT2_FREQ_MHZ <= 0 || 2 * OUT2_FREQ_MHZ > IN_FREQ_MHZ) begin : g_bad_out2
    $error("cpu_clk_gen: OUT2_FREQ_MHZ=%0d out of range for IN_FREQ_MHZ=%0d",
           OUT2_FREQ_MHZ, IN_FREQ_MHZ);
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("cpu_clk_gen: LOCK_CYCLES=%0d must be at least 1", LOCK_CYCLES);
  end

  frac_clk_div #(.INC(2 * OUT1_FREQ_MHZ), .MOD(IN_FREQ_MHZ)) u_div_cpu (
    .clk_in1 (clk_in1),
    .resetn  (resetn),
    .clk_out (clk_out1)
  );

  frac_clk_div #(.INC(2 * OUT2_FREQ_MHZ), .MOD(IN_FREQ_MHZ)) u_div_upg (
    .clk_in1 (clk_in1),
    .resetn  (resetn),
    .clk_out (clk_out2)
  );

  localparam int CW = $clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES);

  logic [CW-1:0] lock_cnt;

  // Counter saturates at LOCK_CYCLES; locked is sticky until the next reset
  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      if (lock_cnt != LOCK_LAST) lock_cnt <= lock_cnt + 1'b1;
      if (lock_cnt == LOCK_LAST - 1'b1) locked <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_clk_gen.sv
// Bench for cpu_clk_gen: closed-form toggle-count reference, phase/rise statistics,
// randomized mid-cycle resets and a 25 MHz parameter override instance.
module tb_cpu_clk_gen;

  localparam int M     = 100;
  localparam int INC1  = 44;
  localparam int INC2  = 20;
  localparam int INC25 = 50;
  localparam int LOCKN = 16;

  logic clk_in1 = 1'b0;
  logic resetn  = 1'b0;
  logic clk_out1, clk_out2, locked;
  logic c25_out1, c25_out2, c25_locked;

  int n_checks = 0;
  int n_errors = 0;
  int n_edge   = 0;
  bit chk_en   = 1'b1;
  bit stats_en = 1'b1;
  int rise1 = 0, rise2 = 0;

  always #5 clk_in1 = ~clk_in1;

  cpu_clk_gen dut (
    .clk_in1  (clk_in1),
    .resetn   (resetn),
    .clk_out1 (clk_out1),
    .clk_out2 (clk_out2),
    .locked   (locked)
  );

  cpu_clk_gen #(.OUT1_FREQ_MHZ(25)) dut25 (
    .clk_in1  (clk_in1),
    .resetn   (resetn),
    .clk_out1 (c25_out1),
    .clk_out2 (c25_out2),
    .locked   (c25_locked)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, got, exp, n_edge, $time);
    end
  endtask

  // Output level after n edges = parity of the number of accumulator wraps, floor(n*INC/M)
  function automatic int model_level(input int n, input int inc);
    return ((n * inc) / M) % 2;
  endfunction

  initial begin
    forever begin
      @(posedge clk_in1 or negedge resetn);
      if (!resetn) n_edge = 0;
      else n_edge = n_edge + 1;
    end
  end

  initial begin : checker_blk
    int p1, p2, last1, last2, len;
    p1 = 0; p2 = 0; last1 = 0; last2 = 0;
    forever begin
      @(negedge clk_in1);
      if (chk_en) begin
        check("clk_out1",  int'(clk_out1),  model_level(n_edge, INC1));
        check("clk_out2",  int'(clk_out2),  model_level(n_edge, INC2));
        check("locked",    int'(locked),    int'(n_edge >= LOCKN));
        check("c25_out1",  int'(c25_out1),  model_level(n_edge, INC25));
        check("c25_out2",  int'(c25_out2),  model_level(n_edge, INC2));
        check("c25_locked", int'(c25_locked), int'(n_edge >= LOCKN));
      end
      if (!resetn) begin
        last1 = 0; last2 = 0;
      end else begin
        if (int'(clk_out1) != p1) begin
          if (stats_en && n_edge >= 101 && n_edge <= 1100 && last1 > 0) begin
            len = n_edge - last1;
            check("c1_phase_2or3", int'(len == 2 || len == 3), 1);
            if (clk_out1) rise1++;
          end
          last1 = n_edge;
        end
        if (int'(clk_out2) != p2) begin
          if (stats_en && n_edge >= 101 && n_edge <= 1100 && last2 > 0) begin
            check("c2_phase_len", n_edge - last2, 5);
            if (clk_out2) rise2++;
          end
          last2 = n_edge;
        end
      end
      p1 = int'(clk_out1);
      p2 = int'(clk_out2);
    end
  end

  // Called right after release on a falling edge; records the edge of each first rise
  task automatic first_rises(input string pfx);
    int f1, f2, fl, f25;
    f1 = -1; f2 = -1; fl = -1; f25 = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk_in1);
      #1;
      if (f1 < 0 && clk_out1) f1 = e;
      if (f2 < 0 && clk_out2) f2 = e;
      if (fl < 0 && locked) fl = e;
      if (f25 < 0 && c25_out1) f25 = e;
    end
    check({pfx, "_first_rise1"}, f1, 3);
    check({pfx, "_first_rise2"}, f2, 5);
    check({pfx, "_first_lock"}, fl, LOCKN);
    check({pfx, "_first_rise25"}, f25, 2);
  endtask

  initial begin : main
    int hold, run, tries;
    repeat (10) @(posedge clk_in1);
    @(negedge clk_in1);
    resetn = 1'b1;
    first_rises("init");

    tries = 0;
    while (n_edge < 1105 && tries < 2000) begin
      @(negedge clk_in1);
      tries++;
    end
    check("window_reached", int'(n_edge >= 1105), 1);
    stats_en = 1'b0;
    check("rise1_count", rise1, 220);
    check("rise2_count", rise2, 100);

    for (int k = 0; k < 4; k++) begin
      run = $urandom_range(20, 300);
      repeat (run) @(negedge clk_in1);
      tries = 0;
      while (!(clk_out1 && clk_out2) && tries < 200) begin
        @(negedge clk_in1);
        tries++;
      end
      check("both_high_found", int'(clk_out1 && clk_out2), 1);
      #($urandom_range(1, 3));
      resetn = 1'b0;
      #1;
      check("async_rst_out1", int'(clk_out1), 0);
      check("async_rst_out2", int'(clk_out2), 0);
      check("async_rst_locked", int'(locked), 0);
      check("async_rst_c25", int'(c25_out1), 0);
      hold = $urandom_range(1, 5);
      repeat (hold) @(negedge clk_in1);
      resetn = 1'b1;
      first_rises("rerel");
    end

    repeat (10000) @(negedge clk_in1);
    check("long_hold_locked", int'(locked), 1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
